// File: rtl/mac_sequencer_if.sv
// Control/operand bundle between the register file, the sequencer and the MAC datapath.
// Register-file side (master) drives the job request; the sequencer (slave) drives the strobes and addresses.
interface mac_sequencer_if #(
   parameter int ADR_W = 8
);
   logic             i_start;
   logic             i_abort;
   logic [7:0]       i_rows;
   logic [7:0]       i_inner;
   logic [7:0]       i_cols;
   logic             o_busy;
   logic             o_done;
   logic             o_err;
   logic [ADR_W-1:0] o_fm_adr;
   logic [ADR_W-1:0] o_sm_adr;
   logic             o_run;
   logic             o_clr;
   logic             o_wr;
   logic [ADR_W-1:0] o_wr_adr;

   modport master (
      output i_start, i_abort, i_rows, i_inner, i_cols,
      input  o_busy, o_done, o_err, o_fm_adr, o_sm_adr, o_run, o_clr, o_wr, o_wr_adr
   );

   modport slave (
      input  i_start, i_abort, i_rows, i_inner, i_cols,
      output o_busy, o_done, o_err, o_fm_adr, o_sm_adr, o_run, o_clr, o_wr, o_wr_adr
   );
endinterface

// File: rtl/mac_sequencer.sv
// Walks A/B/C addresses for C=AxB, one MAC issue per cycle; result writes trail their issue by MAC_LAT.
// Job time from accepted start to done pulse is R*N*K + MAC_LAT + 1; no backpressure, abort cancels at once.
module mac_sequencer #(
   parameter int MAX_DIM = 8,
   parameter int ADR_W   = 8,
   parameter int MAC_LAT = 3
) (
   input  logic           i_wb_clk,
   input  logic           i_wb_rst_n,
   mac_sequencer_if.slave bus
);

   generate
      if (MAX_DIM * MAX_DIM - 1 >= (1 << ADR_W)) begin : g_adr_chk
         $error("ADR_W cannot hold MAX_DIM*MAX_DIM-1");
      end
      if (MAC_LAT < 1) begin : g_lat_chk
         $error("MAC_LAT must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [7:0] MAX_D = 8'(MAX_DIM);

   state_t           state_q, state_d;
   logic [7:0]       rows_q, inner_q, cols_q;
   logic [7:0]       r_q, c_q, k_q;
   logic [ADR_W-1:0] a_base_q, t_adr_q, fm_q, sm_q;
   logic             run_q, clr_q, busy_q, done_q, err_q;
   logic [MAC_LAT-1:0] tag_q;
   logic [ADR_W-1:0] tadr_q [MAC_LAT];

   logic size_bad, k_last, c_last, r_last, last_issue, push, pending, abort_hit;

   assign size_bad   = (bus.i_rows  == 8'd0) || (bus.i_rows  > MAX_D) ||
                       (bus.i_inner == 8'd0) || (bus.i_inner > MAX_D) ||
                       (bus.i_cols  == 8'd0) || (bus.i_cols  > MAX_D);
   assign k_last     = (k_q == inner_q - 8'd1);
   assign c_last     = (c_q == cols_q  - 8'd1);
   assign r_last     = (r_q == rows_q  - 8'd1);
   assign last_issue = run_q && k_last && c_last && r_last;
   assign abort_hit  = bus.i_abort && ((state_q == RUN) || (state_q == DRAIN));
   assign push       = (state_q == RUN) && run_q && k_last && !bus.i_abort;

   // Anything still in flight ahead of the output stage keeps DRAIN alive.
   always_comb begin
      pending = 1'b0;
      for (int j = 0; j < MAC_LAT - 1; j++) begin
         pending = pending | tag_q[j];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.i_start) state_d = size_bad ? DONE : RUN;
         RUN:     if (bus.i_abort) state_d = IDLE;
                  else if (last_issue) state_d = DRAIN;
         DRAIN:   if (bus.i_abort) state_d = IDLE;
                  else if (tag_q[MAC_LAT-1] && !pending) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == RUN) || (state_d == DRAIN);
         done_q  <= (state_d == DONE);
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         rows_q   <= 8'd0;
         inner_q  <= 8'd0;
         cols_q   <= 8'd0;
         r_q      <= 8'd0;
         c_q      <= 8'd0;
         k_q      <= 8'd0;
         a_base_q <= '0;
         t_adr_q  <= '0;
         fm_q     <= '0;
         sm_q     <= '0;
         run_q    <= 1'b0;
         clr_q    <= 1'b0;
         err_q    <= 1'b0;
      end else if ((state_q == IDLE) && bus.i_start) begin
         rows_q   <= bus.i_rows;
         inner_q  <= bus.i_inner;
         cols_q   <= bus.i_cols;
         r_q      <= 8'd0;
         c_q      <= 8'd0;
         k_q      <= 8'd0;
         a_base_q <= '0;
         t_adr_q  <= '0;
         fm_q     <= '0;
         sm_q     <= '0;
         run_q    <= !size_bad;
         clr_q    <= !size_bad;
         err_q    <= size_bad;
      end else if (abort_hit || last_issue) begin
         run_q <= 1'b0;
         clr_q <= 1'b0;
      end else if ((state_q == RUN) && run_q) begin
         if (!k_last) begin
            k_q   <= k_q + 8'd1;
            fm_q  <= fm_q + ADR_W'(1);
            sm_q  <= sm_q + ADR_W'(cols_q);
            clr_q <= 1'b0;
         end else begin
            // Dot product finished: rewind k, step to the next C element.
            k_q     <= 8'd0;
            clr_q   <= 1'b1;
            t_adr_q <= t_adr_q + ADR_W'(1);
            if (!c_last) begin
               c_q  <= c_q + 8'd1;
               fm_q <= a_base_q;
               sm_q <= ADR_W'(c_q) + ADR_W'(1);
            end else begin
               c_q      <= 8'd0;
               r_q      <= r_q + 8'd1;
               a_base_q <= a_base_q + ADR_W'(inner_q);
               fm_q     <= a_base_q + ADR_W'(inner_q);
               sm_q     <= '0;
            end
         end
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         tag_q <= '0;
         for (int j = 0; j < MAC_LAT; j++) tadr_q[j] <= '0;
      end else begin
         tag_q[0]  <= push;
         tadr_q[0] <= t_adr_q;
         for (int j = 1; j < MAC_LAT; j++) begin
            tag_q[j]  <= tag_q[j-1];
            tadr_q[j] <= tadr_q[j-1];
         end
         if (abort_hit) tag_q <= '0;
      end
   end

   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;
   assign bus.o_err    = err_q;
   assign bus.o_fm_adr = fm_q;
   assign bus.o_sm_adr = sm_q;
   assign bus.o_run    = run_q;
   assign bus.o_clr    = clr_q;
   assign bus.o_wr     = tag_q[MAC_LAT-1];
   assign bus.o_wr_adr = tadr_q[MAC_LAT-1];

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: size table plus reset, abort and start-while-busy sequences,
// with a small MAC/memory model that rebuilds C from the strobes and compares it to a golden matmul.
module tb_mac_sequencer;
   localparam int MAX_DIM = 8;
   localparam int ADR_W   = 8;
   localparam int MAC_LAT = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mac_sequencer_if #(.ADR_W(ADR_W)) bus();

   mac_sequencer #(.MAX_DIM(MAX_DIM), .ADR_W(ADR_W), .MAC_LAT(MAC_LAT)) dut (
      .i_wb_clk  (clk),
      .i_wb_rst_n(rst_n),
      .bus       (bus)
   );

   typedef struct {
      int r; int k; int n;
      int exp_err; int exp_runs; int exp_wrs; int exp_done;
   } vec_t;
   vec_t vecs[8];

   int n_checks = 0;
   int n_fail   = 0;

   int     amem [256];
   int     bmem [256];
   longint cmem [256];
   longint acc;
   longint acc_hist [700];
   int     fm_seq [600];
   int     sm_seq [600];
   int     clr_seq [600];
   int     wr_cyc [100];
   int     wr_adr [100];
   bit     busy_arr [700];
   int     run_cnt, wr_cnt, done_cnt, done_cyc, first_run, last_run, err1, err_last;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_job(input int R, input int K, input int N, input int window,
                          input int abort_at, input int pulse_at1, input int pulse_at2);
      run_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
      first_run = -1; last_run = -1; err1 = -1; err_last = -1; acc = 0;
      for (int i = 0; i < 256; i++) cmem[i] = -999;
      for (int i = 0; i < 700; i++) begin busy_arr[i] = 1'b0; acc_hist[i] = 0; end
      @(negedge clk);
      bus.i_rows = 8'(R); bus.i_inner = 8'(K); bus.i_cols = 8'(N);
      bus.i_start = 1'b1; bus.i_abort = 1'b0;
      for (int cyc = 1; cyc <= window; cyc++) begin
         @(negedge clk);
         busy_arr[cyc] = bus.o_busy;
         if (cyc == 1) err1 = int'(bus.o_err);
         err_last = int'(bus.o_err);
         if (bus.o_run) begin
            if (bus.o_clr) acc = longint'(amem[bus.o_fm_adr]) * bmem[bus.o_sm_adr];
            else acc = acc + longint'(amem[bus.o_fm_adr]) * bmem[bus.o_sm_adr];
            if (run_cnt < 600) begin
               fm_seq[run_cnt] = int'(bus.o_fm_adr);
               sm_seq[run_cnt] = int'(bus.o_sm_adr);
               clr_seq[run_cnt] = int'(bus.o_clr);
            end
            if (first_run < 0) first_run = cyc;
            last_run = cyc;
            run_cnt++;
         end
         acc_hist[cyc] = acc;
         if (bus.o_wr) begin
            if (wr_cnt < 100) begin
               wr_cyc[wr_cnt] = cyc;
               wr_adr[wr_cnt] = int'(bus.o_wr_adr);
            end
            if (cyc > MAC_LAT) cmem[bus.o_wr_adr] = acc_hist[cyc - MAC_LAT];
            wr_cnt++;
         end
         if (bus.o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         bus.i_start = (cyc == pulse_at1) || (cyc == pulse_at2);
         bus.i_abort = (cyc == abort_at);
         if (bus.i_start) begin
            bus.i_rows = 8'd1; bus.i_inner = 8'd1; bus.i_cols = 8'd1;
         end else begin
            bus.i_rows = 8'(R); bus.i_inner = 8'(K); bus.i_cols = 8'(N);
         end
      end
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
   endtask

   task automatic check_model(input string tag, input int R, input int K, input int N);
      int idx = 0, j = 0;
      int bad_fm = 0, bad_sm = 0, bad_clr = 0, bad_wc = 0, bad_wa = 0, bad_c = 0;
      int total;
      longint gold;
      total = R * K * N;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < N; c++)
            for (int k = 0; k < K; k++) begin
               if (idx < 600) begin
                  if (fm_seq[idx] != r * K + k) bad_fm++;
                  if (sm_seq[idx] != k * N + c) bad_sm++;
                  if (clr_seq[idx] != ((k == 0) ? 1 : 0)) bad_clr++;
               end
               if (k == K - 1) begin
                  if (j < 100 && j < wr_cnt) begin
                     if (wr_cyc[j] != idx + 1 + MAC_LAT) bad_wc++;
                     if (wr_adr[j] != r * N + c) bad_wa++;
                  end
                  j++;
               end
               idx++;
            end
      for (int r = 0; r < R; r++)
         for (int c = 0; c < N; c++) begin
            gold = 0;
            for (int k = 0; k < K; k++) gold += longint'(amem[r * K + k]) * bmem[k * N + c];
            if (cmem[r * N + c] != gold) bad_c++;
         end
      check({tag, " run_count"}, run_cnt, total);
      check({tag, " first_run_cycle"}, first_run, 1);
      check({tag, " last_run_cycle"}, last_run, total);
      check({tag, " fm_adr_errors"}, bad_fm, 0);
      check({tag, " sm_adr_errors"}, bad_sm, 0);
      check({tag, " clr_errors"}, bad_clr, 0);
      check({tag, " wr_count"}, wr_cnt, R * N);
      check({tag, " wr_cycle_errors"}, bad_wc, 0);
      check({tag, " wr_adr_errors"}, bad_wa, 0);
      check({tag, " c_result_errors"}, bad_c, 0);
      check({tag, " done_count"}, done_cnt, 1);
      check({tag, " done_cycle"}, done_cyc, total + MAC_LAT + 1);
      check({tag, " err_at_start"}, err1, 0);
      check({tag, " busy_cycle1"}, int'(busy_arr[1]), 1);
      check({tag, " busy_last_drain"}, int'(busy_arr[total + MAC_LAT]), 1);
      check({tag, " busy_at_done"}, int'(busy_arr[total + MAC_LAT + 1]), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2, 2, 2, 0,   8,  4,  12};
      vecs[1] = '{1, 8, 1, 0,   8,  1,  12};
      vecs[2] = '{0, 2, 2, 1,   0,  0,   1};
      vecs[3] = '{3, 1, 2, 0,   6,  6,  10};
      vecs[4] = '{2, 2, 9, 1,   0,  0,   1};
      vecs[5] = '{1, 1, 1, 0,   1,  1,   5};
      vecs[6] = '{3, 2, 4, 0,  24, 12,  28};
      vecs[7] = '{8, 8, 8, 0, 512, 64, 516};
      for (int i = 0; i < 256; i++) begin
         amem[i] = (i * 5 + 1) % 9 - 3;
         bmem[i] = (i * 3 + 2) % 7;
      end
      bus.i_start = 1'b0; bus.i_abort = 1'b0;
      bus.i_rows = 8'd0; bus.i_inner = 8'd0; bus.i_cols = 8'd0;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", int'(bus.o_busy), 0);
      check("reset done", int'(bus.o_done), 0);
      check("reset err", int'(bus.o_err), 0);
      check("reset run", int'(bus.o_run), 0);
      check("reset clr", int'(bus.o_clr), 0);
      check("reset wr", int'(bus.o_wr), 0);
      check("reset fm_adr", int'(bus.o_fm_adr), 0);
      check("reset sm_adr", int'(bus.o_sm_adr), 0);
      check("reset wr_adr", int'(bus.o_wr_adr), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         run_job(vecs[v].r, vecs[v].k, vecs[v].n,
                 vecs[v].exp_err ? 4 : vecs[v].exp_done + 2, -1, -1, -1);
         check($sformatf("vec%0d err", v), err1, vecs[v].exp_err);
         check($sformatf("vec%0d runs", v), run_cnt, vecs[v].exp_runs);
         check($sformatf("vec%0d wrs", v), wr_cnt, vecs[v].exp_wrs);
         check($sformatf("vec%0d done_cycle", v), done_cyc, vecs[v].exp_done);
         if (vecs[v].exp_err != 0) begin
            check($sformatf("vec%0d err_held", v), err_last, 1);
            check($sformatf("vec%0d busy_cycle1", v), int'(busy_arr[1]), 0);
            check($sformatf("vec%0d done_count", v), done_cnt, 1);
         end else begin
            check_model($sformatf("vec%0d", v), vecs[v].r, vecs[v].k, vecs[v].n);
         end
      end

      // Asynchronous reset in the middle of a running job.
      @(negedge clk);
      bus.i_rows = 8'd2; bus.i_inner = 8'd2; bus.i_cols = 8'd2; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      check("midrun pre busy", int'(bus.o_busy), 1);
      check("midrun pre fm_adr", int'(bus.o_fm_adr), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrun reset busy", int'(bus.o_busy), 0);
      check("midrun reset run", int'(bus.o_run), 0);
      check("midrun reset fm_adr", int'(bus.o_fm_adr), 0);
      check("midrun reset sm_adr", int'(bus.o_sm_adr), 0);
      check("midrun reset clr", int'(bus.o_clr), 0);
      check("midrun reset wr", int'(bus.o_wr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_job(2, 2, 2, 14, -1, -1, -1);
      check_model("after_reset", 2, 2, 2);

      // Abort during DRAIN: writes at 5,7,9 seen, the one due at 11 is flushed.
      run_job(2, 2, 2, 15, 9, -1, -1);
      check("abort_drain wr_count", wr_cnt, 3);
      check("abort_drain done_count", done_cnt, 0);
      check("abort_drain busy_before", int'(busy_arr[9]), 1);
      check("abort_drain busy_after", int'(busy_arr[10]), 0);
      check("abort_drain run_count", run_cnt, 8);
      run_job(2, 2, 2, 14, -1, -1, -1);
      check_model("restart_after_abort", 2, 2, 2);

      // Abort during RUN before any write is due.
      run_job(2, 2, 2, 15, 3, -1, -1);
      check("abort_run run_count", run_cnt, 3);
      check("abort_run wr_count", wr_cnt, 0);
      check("abort_run done_count", done_cnt, 0);
      check("abort_run busy_after", int'(busy_arr[4]), 0);

      // Start pulses while busy and in DONE must be ignored.
      run_job(2, 2, 2, 15, -1, 3, 12);
      check_model("start_while_busy", 2, 2, 2);
      check("start_in_done busy", int'(busy_arr[13]), 0);
      check("start_in_done busy2", int'(busy_arr[15]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
